snn_layer_ctrl: RTL

SNN_LAYER_CTRL -- requirements
Module: snn_layer_ctrl

---
 rtl/snn_layer_ctrl_if.sv | 62 ++++++
 rtl/snn_layer_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/snn_layer_ctrl_if.sv
// ---------------------------------------------------------------------------
// snn_layer_ctrl_if
//
// Bundle of every handshake and bus signal of the SNN layer controller.
// The controller connects through the 'slave' modport; the surrounding
// system (input spike source, weight memory, neuron array, output sink)
// connects through the 'master' modport.
//
// Signal groups:
//   run control   : start (in), busy (out), done (out, 1-cycle pulse)
//   input spikes  : in_valid (in), in_ready (out), in_spikes[N_IN] (in)
//   weight read   : w_rd_en (out), w_addr (out), w_rdata (in, 1-cycle latency)
//   neuron array  : neu_clken, neu_clr, neu_data_in (out), neu_spike (in)
//   output spikes : out_valid (out), out_ready (in), out_spikes[N_NEU] (out)
//
// Directions above are as seen from the controller.
// ---------------------------------------------------------------------------
interface snn_layer_ctrl_if #(
    parameter int N_IN         = 16,
    parameter int N_NEU        = 8,
    parameter int WEIGHT_WIDTH = 8
);
    localparam int ADDR_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    // Run control
    logic                          start;
    logic                          busy;
    logic                          done;

    // Input spike vector handshake
    logic                          in_valid;
    logic                          in_ready;
    logic [N_IN-1:0]               in_spikes;

    // Weight-row read port; slice j of w_rdata is the weight for neuron j
    logic                          w_rd_en;
    logic [ADDR_W-1:0]             w_addr;
    logic [N_NEU*WEIGHT_WIDTH-1:0] w_rdata;

    // Neuron array control and spike return
    logic [N_NEU-1:0]              neu_clken;
    logic [N_NEU-1:0]              neu_clr;
    logic [N_NEU*WEIGHT_WIDTH-1:0] neu_data_in;
    logic [N_NEU-1:0]              neu_spike;

    // Per-timestep output spike vector handshake
    logic                          out_valid;
    logic                          out_ready;
    logic [N_NEU-1:0]              out_spikes;

    modport slave (
        input  start, in_valid, in_spikes, w_rdata, neu_spike, out_ready,
        output busy, done, in_ready, w_rd_en, w_addr,
               neu_clken, neu_clr, neu_data_in, out_valid, out_spikes
    );

    modport master (
        output start, in_valid, in_spikes, w_rdata, neu_spike, out_ready,
        input  busy, done, in_ready, w_rd_en, w_addr,
               neu_clken, neu_clr, neu_data_in, out_valid, out_spikes
    );
endinterface

// File: rtl/snn_layer_ctrl.sv
// ---------------------------------------------------------------------------
// snn_layer_ctrl
//
// Sequencer for one fully connected spiking-neuron layer. A run lasts
// T_STEPS timesteps. Each timestep:
//   1. accept one presynaptic spike vector (in_valid/in_ready),
//   2. scan every input index in order; for each set spike bit read the
//      weight row from memory and, one cycle later, accumulate that row
//      into all neurons (neu_clken all-ones, neu_data_in = row),
//   3. sample the neuron spike outputs, reset every neuron that fired,
//   4. present the spike vector on out_valid/out_ready.
// The neurons are cleared once at the start of each run (CLEAR state);
// membrane state is intentionally kept across the end of a run.
//
// Ports:
//   clk   : single clock, rising edge
//   nRST  : asynchronous active-low reset
//   bus   : snn_layer_ctrl_if.slave (run control, input/output spike
//           handshakes, weight read port, neuron array control)
//
// Timing: with the in_valid/in_ready handshake in cycle 0, SCAN occupies
// cycles 1..N_IN, DRAIN N_IN+1, FIRE N_IN+2 and out_valid rises in cycle
// N_IN+3.
// ---------------------------------------------------------------------------
module snn_layer_ctrl #(
    parameter int N_IN         = 16,
    parameter int N_NEU        = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int T_STEPS      = 16
) (
    input  logic             clk,
    input  logic             nRST,
    snn_layer_ctrl_if.slave  bus
);
    localparam int ADDR_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    // One extra bit so the counter can hold T_STEPS after the last step.
    localparam int STEP_W = $clog2(T_STEPS + 1);
    localparam int ROW_W  = N_NEU * WEIGHT_WIDTH;

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_IN - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(T_STEPS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT_IN,
        SCAN,
        DRAIN,
        FIRE,
        OUT,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [N_IN-1:0]    spikes_q, spikes_d;
    logic [N_NEU-1:0]   out_spikes_q, out_spikes_d;
    // Set in the cycle after a weight read was issued: the row arriving on
    // w_rdata in that cycle must be accumulated into the neurons.
    logic               acc_q, acc_d;

    logic [ROW_W-1:0]   acc_row;

    assign acc_row        = bus.w_rdata;
    assign bus.out_spikes = out_spikes_q;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values computed before this edge, independent of
    // process evaluation order.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            step_q       <= '0;
            spikes_q     <= '0;
            out_spikes_q <= '0;
            acc_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            step_q       <= step_d;
            spikes_q     <= spikes_d;
            out_spikes_q <= out_spikes_d;
            acc_q        <= acc_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default at the top; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        step_d          = step_q;
        spikes_d        = spikes_q;
        out_spikes_d    = out_spikes_q;
        acc_d           = 1'b0;

        bus.busy        = (state_q != IDLE);
        bus.done        = 1'b0;
        bus.in_ready    = 1'b0;
        bus.w_rd_en     = 1'b0;
        bus.w_addr      = '0;
        bus.neu_clken   = '0;
        bus.neu_clr     = '0;
        bus.neu_data_in = '0;
        bus.out_valid   = 1'b0;

        // Accumulate stage of the read pipeline. It runs alongside the scan
        // (SCAN idx>=1) and in DRAIN, so one index per cycle is sustained.
        // acc_q is never set in CLEAR or FIRE, so no conflict below.
        if (acc_q) begin
            bus.neu_clken   = '1;
            bus.neu_data_in = acc_row;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CLEAR;
                end
            end

            CLEAR: begin
                bus.neu_clken = '1;
                bus.neu_clr   = '1;
                step_d        = '0;
                state_d       = WAIT_IN;
            end

            WAIT_IN: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    spikes_d = bus.in_spikes;
                    idx_d    = '0;
                    state_d  = SCAN;
                end
            end

            SCAN: begin
                // The address is walked even for zero bits so the timestep
                // length does not depend on spike density.
                bus.w_addr  = idx_q;
                bus.w_rd_en = spikes_q[idx_q];
                acc_d       = spikes_q[idx_q];
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end

            DRAIN: begin
                // Only the pending accumulate of the last index happens here.
                state_d = FIRE;
            end

            FIRE: begin
                // Membranes now include every accumulate of this timestep.
                // Neurons that fired are reset to zero in the same cycle.
                out_spikes_d  = bus.neu_spike;
                bus.neu_clken = bus.neu_spike;
                bus.neu_clr   = bus.neu_spike;
                state_d       = OUT;
            end

            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    step_d  = step_q + STEP_W'(1);
                    state_d = (step_q == LAST_STEP) ? DONE : WAIT_IN;
                end
            end

            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule
